intr_ctrl: RTL and testbench

- Interrupt request controller directly upstream of the microcode sequencer's interrupt dispatch.
- Collects up to 32 sticky interrupt causes (int1..int32) and applies the mask.
- Selects the highest-priority cause and presents its 5-bit vector, which indexes `intrtab[]`, to the sequencer under a req/ack handshake.
- Also generates the "time-out while external interrupts blocked" cause (int27) internally.

---
 rtl/intr_ctrl.sv | 111 +++++++++++
 tb/tb_intr_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Interrupt request controller: sticky causes, mask, lowest-index priority,
// req/ack/done handshake to the sequencer, plus the blocked-external timeout cause.
module intr_ctrl #(
  parameter int NINTR   = 32,
  parameter int EXT_IDX = 29,
  parameter int TO_IDX  = 26,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NINTR-1:0] i_req,
  input  logic [NINTR-1:0] i_clr,
  input  logic             i_mask_wr,
  input  logic [NINTR-1:0] i_mask,
  input  logic             i_ext_block,
  input  logic             i_ack,
  input  logic             i_done,
  output logic             o_irq,
  output logic [4:0]       o_vec,
  output logic             o_busy,
  output logic [NINTR-1:0] o_pending,
  output logic [NINTR-1:0] o_mask
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state, state_nx;
  logic [NINTR-1:0] pending, mask, pend_nx, elig, ack_clear, to_set;
  logic [CW-1:0]    to_cnt;
  logic [4:0]       vec, sel;
  logic             to_run, to_fire, ack_take, withdraw;

  // Timeout counts only while the external cause is both pending and blocked.
  assign to_run  = i_ext_block && pending[EXT_IDX];
  assign to_fire = to_run && (to_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset)       to_cnt <= '0;
    else if (to_fire) to_cnt <= '0;
    else if (to_run)  to_cnt <= to_cnt + CW'(1);
    else              to_cnt <= '0;
  end

  always_comb begin
    to_set         = '0;
    to_set[TO_IDX] = to_fire;
  end

  assign ack_take = (state == REQ) && i_ack;

  always_comb begin
    ack_clear      = '0;
    ack_clear[vec] = ack_take;
  end

  // Sets are OR'd in last so a same-cycle set beats any clear.
  assign pend_nx = (pending & ~i_clr & ~ack_clear) | i_req | to_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= pend_nx;
      if (i_mask_wr) mask <= i_mask;
    end
  end

  always_comb begin
    elig = pending & ~mask;
    if (i_ext_block) elig[EXT_IDX] = 1'b0;
  end

  always_comb begin
    sel = '0;
    for (int i = NINTR - 1; i >= 0; i--)
      if (elig[i]) sel = 5'(i);
  end

  assign withdraw = !pend_nx[vec] || mask[vec];

  always_ff @(posedge clk) begin
    if (reset)                       vec <= '0;
    else if (state == IDLE && |elig) vec <= sel;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|elig) state_nx = REQ;
      REQ:     if (i_ack) state_nx = SERVICE;
               else if (withdraw) state_nx = IDLE;
      SERVICE: if (i_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_irq     = (state == REQ);
    o_busy    = (state == SERVICE);
    o_vec     = vec;
    o_pending = pending;
    o_mask    = mask;
  end
endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: stimulus pushes predicted outputs, a monitor pops/compares.
module tb_intr_ctrl;
  localparam int TOUT = 16;
  localparam int EXT  = 29;
  localparam int TO   = 26;

  logic        clk = 1'b0;
  logic        r_reset = 1'b1, r_mwr = 1'b0, r_blk = 1'b0, r_ack = 1'b0, r_done = 1'b0;
  logic [31:0] r_req = '0, r_clr = '0, r_mask = '0;
  logic        o_irq, o_busy;
  logic [4:0]  o_vec;
  logic [31:0] o_pending, o_mask;

  always #5 clk = ~clk;

  intr_ctrl #(.NINTR(32), .EXT_IDX(EXT), .TO_IDX(TO), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(r_reset), .i_req(r_req), .i_clr(r_clr), .i_mask_wr(r_mwr),
    .i_mask(r_mask), .i_ext_block(r_blk), .i_ack(r_ack), .i_done(r_done),
    .o_irq(o_irq), .o_vec(o_vec), .o_busy(o_busy), .o_pending(o_pending), .o_mask(o_mask)
  );

  typedef struct {
    logic [31:0] pend, mask;
    bit          irq, busy, vchk;
    logic [4:0]  vec;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;

  // Reference model: what the controller should look like after the next edge.
  logic [31:0] m_pend = '0, m_mask = '0;
  bit          m_offer = 0, m_busy = 0, m_rst = 0;
  logic [4:0]  m_vec = '0;
  int          m_cnt = 0;

  function automatic logic [4:0] lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return 5'(i);
    return 5'd0;
  endfunction

  task automatic model_step();
    logic [31:0] elig, npend, nto, ackc;
    m_rst = r_reset;
    if (r_reset) begin
      m_pend = '0; m_mask = '0; m_offer = 0; m_busy = 0; m_vec = '0; m_cnt = 0;
    end else begin
      nto = '0;
      if (r_blk && m_pend[EXT]) begin
        if (m_cnt == TOUT - 1) begin nto[TO] = 1'b1; m_cnt = 0; end
        else m_cnt++;
      end else m_cnt = 0;
      elig = m_pend & ~m_mask;
      if (r_blk) elig[EXT] = 1'b0;
      ackc = '0;
      if (m_offer && r_ack) ackc[m_vec] = 1'b1;
      npend = (m_pend & ~r_clr & ~ackc) | r_req | nto;
      if (m_offer) begin
        if (r_ack) begin m_offer = 0; m_busy = 1; end
        else if (!npend[m_vec] || m_mask[m_vec]) m_offer = 0;
      end else if (m_busy) begin
        if (r_done) m_busy = 0;
      end else if (elig != 0) begin
        m_vec = lowest(elig); m_offer = 1;
      end
      m_pend = npend;
      if (r_mwr) m_mask = r_mask;
    end
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    e.pend = m_pend; e.mask = m_mask; e.irq = m_offer; e.busy = m_busy;
    e.vec = m_vec; e.vchk = m_offer || m_rst;
    q.push_back(e);
    @(negedge clk);
    r_reset = 0; r_req = '0; r_clr = '0; r_mwr = 0; r_ack = 0; r_done = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("o_irq", 32'(o_irq), 32'(e.irq));
        chk("o_busy", 32'(o_busy), 32'(e.busy));
        chk("o_pending", o_pending, e.pend);
        chk("o_mask", o_mask, e.mask);
        if (e.vchk) chk("o_vec", 32'(o_vec), 32'(e.vec));
      end
    end
  end

  initial begin : stim
    r_reset = 1; tick(); r_reset = 1; tick();
    // single cause, ack at cycle 4, then done
    r_req = 32'h20; tick(); ticks(3); r_ack = 1; tick(); tick(); r_done = 1; tick(); tick();
    // two simultaneous causes, priority order 8 then 11
    r_req = 32'h900; tick(); ticks(3); r_ack = 1; tick(); r_done = 1; tick();
    ticks(3); r_ack = 1; tick(); r_done = 1; tick(); tick();
    // masked cause waits, then unmask
    r_mwr = 1; r_mask = 32'h100; tick(); r_req = 32'h100; tick(); ticks(20);
    r_mwr = 1; r_mask = 32'h0; tick(); ticks(4); r_ack = 1; tick(); r_done = 1; tick();
    // withdraw on clear; same-cycle set+clear keeps the bit
    r_req = 32'h8; tick(); ticks(2); r_clr = 32'h8; tick(); ticks(2);
    r_req = 32'h8; tick(); ticks(2); r_req = 32'h8; r_clr = 32'h8; tick(); ticks(3);
    r_ack = 1; tick(); r_done = 1; tick();
    // blocked external cause raises the timeout cause
    r_blk = 1; r_req = 32'h1 << EXT; tick(); ticks(20); r_ack = 1; tick();
    r_blk = 0; r_done = 1; tick(); ticks(3); r_ack = 1; tick(); r_done = 1; tick(); ticks(3);
    r_ack = 1; tick(); r_done = 1; tick();
    // reset in SERVICE and in REQ
    r_req = 32'h1; tick(); ticks(2); r_ack = 1; tick(); r_reset = 1; tick();
    r_req = 32'h2; tick(); ticks(2); r_reset = 1; tick();
    r_req = 32'h1; tick(); ticks(3); r_ack = 1; tick(); r_done = 1; tick();
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) r_req = 32'h1 << $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) r_req = r_req | $urandom;
      if ($urandom_range(0, 7) == 0) r_clr = 32'h1 << $urandom_range(0, 31);
      if ($urandom_range(0, 19) == 0) begin r_mwr = 1; r_mask = $urandom & $urandom & $urandom; end
      if ($urandom_range(0, 29) == 0) r_blk = ~r_blk;
      r_ack  = ($urandom_range(0, 2) == 0);
      r_done = ($urandom_range(0, 3) == 0);
      r_reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    r_blk = 0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
